piso_tx: RTL

//  Parallel-in/serial-out transmitter: the driving end of our flop-based serial capture path.

---
 rtl/piso_tx_pkg.sv | 19 +
 rtl/piso_tx_shreg.sv | 48 ++++
 rtl/piso_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg
//   Shared definitions for the parallel-in/serial-out transmitter.
//   - state_t : transmitter FSM states (PARITY is only reachable when
//               PISO_TX_PARITY_EN is defined)
//   - cnt_w   : width of the per-frame bit counter for a given WIDTH
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Counter runs WIDTH-1 down to 0; keep at least one bit for WIDTH=2.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_shreg.sv
// piso_tx_shreg
//   WIDTH-bit load/shift register feeding the serial output.
//   On load, the first bit of i_data goes straight to the caller via o_first
//   and the register keeps the remaining bits, so o_bit always shows the bit
//   that is due next. MSB_FIRST selects the shift direction.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_data (takes priority over i_shift)
//   i_shift        : advance by one bit
//   i_data         : word to transmit
//   o_first        : first bit of i_data (combinational)
//   o_bit          : next bit to transmit from the stored word
module piso_tx_shreg
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_first,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_shift_val;

  // The first bit leaves through o_first, so it is dropped from the stored word.
  assign o_first     = MSB_FIRST ? i_data[WIDTH-1] : i_data[0];
  assign o_bit       = MSB_FIRST ? r_sh[WIDTH-1]   : r_sh[0];
  assign w_load_val  = MSB_FIRST ? {i_data[WIDTH-2:0], 1'b0} : {1'b0, i_data[WIDTH-1:1]};
  assign w_shift_val = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0}   : {1'b0, r_sh[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= w_load_val;
    end else if (i_shift) begin
      r_sh <= w_shift_val;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx
//   Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready handshake and sends it one bit per clk on sout with
//   sout_valid and a start-of-frame marker (sof). Back-to-back frames are
//   gapless when a new word is accepted on the last-bit cycle.
//   Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit
//   per frame (frame = WIDTH+1 cycles); ready then moves to the parity cycle.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_valid  : load_data valid
//   load_data   : word to transmit
//   load_ready  : a word can be accepted this cycle (registered)
//   sout        : serial data bit (registered)
//   sout_valid  : sout carries a frame bit (registered)
//   sof         : first bit of a frame (registered)
//   busy        : frame in progress
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_sout;
  logic          r_sout_valid;
  logic          r_sof;
`ifdef PISO_TX_PARITY_EN
  logic          r_par;
`endif

  logic w_accept;
  logic w_last;
  logic w_shift;
  logic w_first;
  logic w_bit;

  assign w_accept = load_valid && r_ready;
  assign w_last   = (r_cnt == '0);
  assign w_shift  = (r_state == SHIFT) && !w_last;

  piso_tx_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (load_data),
    .o_first (w_first),
    .o_bit   (w_bit)
  );

  // load_ready is registered: it is the next-state decode of "will be in a
  // cycle where a word may be taken", so it stays low until the first edge
  // after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_sof        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_accept) begin
      // Accept is only possible in IDLE, on the last data bit, or in PARITY.
      r_state      <= SHIFT;
      r_cnt        <= CNT_LAST;
      r_ready      <= 1'b0;
      r_sout       <= w_first;
      r_sout_valid <= 1'b1;
      r_sof        <= 1'b1;
`ifdef PISO_TX_PARITY_EN
      r_par        <= ^load_data;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (!w_last) begin
            r_cnt        <= r_cnt - CW'(1);
            r_sout       <= w_bit;
            r_sout_valid <= 1'b1;
            r_sof        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_ready      <= 1'b0;
`else
            r_ready      <= (r_cnt == CW'(1));
`endif
          end else begin
`ifdef PISO_TX_PARITY_EN
            r_state      <= PARITY;
            r_sout       <= r_par;
            r_sout_valid <= 1'b1;
`else
            r_state      <= IDLE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
`endif
            r_sof        <= 1'b0;
            r_ready      <= 1'b1;
          end
        end
        default: begin
          // IDLE, or PARITY with no accept: drop to / stay in IDLE.
          r_state      <= IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_sof        <= 1'b0;
          r_ready      <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = r_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign sof        = r_sof;
  assign busy       = (r_state != IDLE);

endmodule
